// File: rtl/dp_pairhmm_pe_v2.sv
// rtl/dp_pairhmm_pe_v2.sv - Parametrised PairHMM systolic PE with prior table, saturation and argmax
//
// Computes one log-domain PairHMM DP cell per enabled cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   refresh              synchronous clear of datapath state (table kept)
//   i_en                 input cell valid
//   i_hap_base/read_base base codes; i_read_n forces a neutral prior
//   i_read_qual          prior table index
//   i_A_top_add_M2I, i_I_top, i_A_diag, i_INDEL_diag  neighbour scores
//   cfg_we/qual/match/mismatch  prior table write port
//   o_INDEL_dd, o_I_d, o_A_dd, o_A_d_add_M2I, o_Max  scores
//   o_valid_d/dd/ddd     valid pipeline; o_hap_base registered base
//   o_max_pos            column of o_Max; o_sat sticky saturation flag
module dp_pairhmm_pe_v2 #(
  parameter int SCORE_W      = 16,
  parameter int QUAL_W       = 2,
  parameter int PRIOR_W      = 8,
  parameter int POS_W        = 10,
  parameter int M2M          = -1,
  parameter int I2M          = -4,
  parameter int M2I          = -6,
  parameter int I2I          = -2,
  parameter int DEF_MATCH    = 2,
  parameter int DEF_MISMATCH = -8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      refresh,
  input  logic                      i_en,
  input  logic [1:0]                i_hap_base,
  input  logic [1:0]                i_read_base,
  input  logic                      i_read_n,
  input  logic [QUAL_W-1:0]         i_read_qual,
  input  logic signed [SCORE_W-1:0] i_A_top_add_M2I,
  input  logic signed [SCORE_W-1:0] i_I_top,
  input  logic signed [SCORE_W-1:0] i_A_diag,
  input  logic signed [SCORE_W-1:0] i_INDEL_diag,
  input  logic                      cfg_we,
  input  logic [QUAL_W-1:0]         cfg_qual,
  input  logic signed [PRIOR_W-1:0] cfg_match,
  input  logic signed [PRIOR_W-1:0] cfg_mismatch,
  output logic signed [SCORE_W-1:0] o_INDEL_dd,
  output logic signed [SCORE_W-1:0] o_I_d,
  output logic signed [SCORE_W-1:0] o_A_dd,
  output logic signed [SCORE_W-1:0] o_A_d_add_M2I,
  output logic signed [SCORE_W-1:0] o_Max,
  output logic                      o_valid_d,
  output logic                      o_valid_dd,
  output logic                      o_valid_ddd,
  output logic [1:0]                o_hap_base,
  output logic [POS_W-1:0]          o_max_pos,
  output logic                      o_sat
);
  localparam int XW = SCORE_W + 2;
  localparam int NQ = 1 << QUAL_W;
  localparam logic signed [SCORE_W-1:0] S_NEG = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] S_POS = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [XW-1:0]      X_NEG = {3'b111, {(SCORE_W-1){1'b0}}};
  localparam logic signed [XW-1:0]      X_POS = {3'b000, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] C_M2M = SCORE_W'(M2M);
  localparam logic signed [SCORE_W-1:0] C_I2M = SCORE_W'(I2M);
  localparam logic signed [SCORE_W-1:0] C_M2I = SCORE_W'(M2I);
  localparam logic signed [SCORE_W-1:0] C_I2I = SCORE_W'(I2I);

  // Saturating add in SCORE_W+2 bits. Returns {event, result}; a clamp of a
  // -inf (MOST_NEG) accumulator is not an event.
  function automatic logic [SCORE_W:0] f_sadd(input logic signed [SCORE_W-1:0] a,
                                                input logic signed [SCORE_W-1:0] b);
    logic signed [XW-1:0] s;
    logic [SCORE_W-1:0]   r;
    logic                 hit;
    s   = $signed({{2{a[SCORE_W-1]}}, a}) + $signed({{2{b[SCORE_W-1]}}, b});
    hit = 1'b1;
    if (s > X_POS)      r = S_POS;
    else if (s < X_NEG) r = S_NEG;
    else begin
      r   = s[SCORE_W-1:0];
      hit = 1'b0;
    end
    return {hit && (a != S_NEG), r};
  endfunction

  function automatic logic signed [SCORE_W-1:0] f_max(input logic signed [SCORE_W-1:0] a,
                                                      input logic signed [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic signed [PRIOR_W-1:0] r_tab_match [NQ];
  logic signed [PRIOR_W-1:0] r_tab_mis   [NQ];
  logic signed [SCORE_W-1:0] r_A_d, r_I_d, r_D_d, r_A_dd, r_INDEL_dd, r_V_dd, r_Max;
  logic [POS_W-1:0]          r_col, r_col_d, r_pos_dd, r_max_pos;
  logic                      r_valid_d, r_valid_dd, r_valid_ddd, r_sat;
  logic [1:0]                r_hap;

  logic signed [PRIOR_W-1:0] w_prior_raw;
  logic signed [SCORE_W-1:0] w_prior;
  logic [SCORE_W:0]          w_a1_x, w_a2_x, w_ad_x, w_it_x, w_dt_x, w_m2i_x;
  logic signed [SCORE_W-1:0] w_a1, w_a2, w_am, w_ad, w_it, w_id, w_dt, w_m2i, w_dd;
  logic                      w_sat_d;

  // Table read sees the pre-write contents when cfg_we hits the same index.
  assign w_prior_raw = (i_hap_base == i_read_base) ? r_tab_match[i_read_qual]
                                                   : r_tab_mis[i_read_qual];
  assign w_prior     = i_read_n ? '0 : SCORE_W'(w_prior_raw);

  assign w_a1_x  = f_sadd(i_A_diag, C_M2M);
  assign w_a2_x  = f_sadd(i_INDEL_diag, C_I2M);
  assign w_a1    = w_a1_x[SCORE_W-1:0];
  assign w_a2    = w_a2_x[SCORE_W-1:0];
  assign w_am    = f_max(w_a1, w_a2);
  assign w_ad_x  = f_sadd(w_am, w_prior);
  assign w_ad    = w_ad_x[SCORE_W-1:0];
  assign w_it_x  = f_sadd(i_I_top, C_I2I);
  assign w_it    = w_it_x[SCORE_W-1:0];
  assign w_id    = f_max(i_A_top_add_M2I, w_it);
  // Deletion extends horizontally from the previous cell held in this PE.
  assign w_m2i_x = f_sadd(r_A_d, C_M2I);
  assign w_m2i   = w_m2i_x[SCORE_W-1:0];
  assign w_dt_x  = f_sadd(r_D_d, C_I2I);
  assign w_dt    = w_dt_x[SCORE_W-1:0];
  assign w_dd    = f_max(w_m2i, w_dt);
  assign w_sat_d = w_a1_x[SCORE_W] | w_a2_x[SCORE_W] | w_ad_x[SCORE_W] |
                   w_it_x[SCORE_W] | w_dt_x[SCORE_W] | w_m2i_x[SCORE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        r_tab_match[q] <= PRIOR_W'(DEF_MATCH);
        r_tab_mis[q]   <= PRIOR_W'(DEF_MISMATCH);
      end
    end else if (cfg_we) begin
      r_tab_match[cfg_qual] <= cfg_match;
      r_tab_mis[cfg_qual]   <= cfg_mismatch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_A_d <= S_NEG; r_I_d <= S_NEG; r_D_d <= S_NEG; r_A_dd <= S_NEG;
      r_INDEL_dd <= S_NEG; r_V_dd <= S_NEG; r_Max <= S_NEG;
      r_col <= '0; r_col_d <= '0; r_pos_dd <= '0; r_max_pos <= '0;
      r_valid_d <= 1'b0; r_valid_dd <= 1'b0; r_valid_ddd <= 1'b0;
      r_sat <= 1'b0; r_hap <= '0;
    end else if (refresh) begin
      r_A_d <= S_NEG; r_I_d <= S_NEG; r_D_d <= S_NEG; r_A_dd <= S_NEG;
      r_INDEL_dd <= S_NEG; r_V_dd <= S_NEG; r_Max <= S_NEG;
      r_col <= '0; r_col_d <= '0; r_pos_dd <= '0; r_max_pos <= '0;
      r_valid_d <= 1'b0; r_valid_dd <= 1'b0; r_valid_ddd <= 1'b0;
      r_sat <= 1'b0; r_hap <= '0;
    end else begin
      r_A_dd      <= r_A_d;
      r_hap       <= i_hap_base;
      r_valid_d   <= i_en;
      r_valid_dd  <= r_valid_d;
      r_valid_ddd <= r_valid_dd;
      if (i_en) begin
        r_A_d   <= w_ad;
        r_I_d   <= w_id;
        r_D_d   <= w_dd;
        r_col_d <= r_col;
        r_col   <= r_col + POS_W'(1);
        r_sat   <= r_sat | w_sat_d;
      end
      if (r_valid_d) begin
        r_INDEL_dd <= f_max(r_D_d, r_I_d);
        r_V_dd     <= f_max(r_I_d, r_A_d);
        r_pos_dd   <= r_col_d;
      end
      // Strict compare keeps the earliest column on ties.
      if (r_valid_dd && (r_V_dd > r_Max)) begin
        r_Max     <= r_V_dd;
        r_max_pos <= r_pos_dd;
      end
    end
  end

  assign o_INDEL_dd    = r_INDEL_dd;
  assign o_I_d         = r_I_d;
  assign o_A_dd        = r_A_dd;
  assign o_A_d_add_M2I = w_m2i;
  assign o_Max         = r_Max;
  assign o_valid_d     = r_valid_d;
  assign o_valid_dd    = r_valid_dd;
  assign o_valid_ddd   = r_valid_ddd;
  assign o_hap_base    = r_hap;
  assign o_max_pos     = r_max_pos;
  assign o_sat         = r_sat;
endmodule

// File: tb/tb_dp_pairhmm_pe_v2.sv
// tb/tb_dp_pairhmm_pe_v2.sv - Self-checking bench for dp_pairhmm_pe_v2
module tb_dp_pairhmm_pe_v2;
  localparam int NEG = -32768;
  localparam int POS = 32767;
  localparam int M2M = -1, I2M = -4, M2I = -6, I2I = -2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic refresh = 1'b0, i_en = 1'b0, i_read_n = 1'b0, cfg_we = 1'b0;
  logic [1:0] i_hap_base = '0, i_read_base = '0;
  logic [1:0] i_read_qual = '0, cfg_qual = '0;
  logic signed [15:0] i_A_top_add_M2I = '0, i_I_top = '0, i_A_diag = '0, i_INDEL_diag = '0;
  logic signed [7:0]  cfg_match = '0, cfg_mismatch = '0;
  logic signed [15:0] o_INDEL_dd, o_I_d, o_A_dd, o_A_d_add_M2I, o_Max;
  logic o_valid_d, o_valid_dd, o_valid_ddd, o_sat;
  logic [1:0] o_hap_base;
  logic [9:0] o_max_pos;

  always #5 clk = ~clk;

  dp_pairhmm_pe_v2 dut (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .i_en(i_en),
    .i_hap_base(i_hap_base), .i_read_base(i_read_base), .i_read_n(i_read_n),
    .i_read_qual(i_read_qual), .i_A_top_add_M2I(i_A_top_add_M2I), .i_I_top(i_I_top),
    .i_A_diag(i_A_diag), .i_INDEL_diag(i_INDEL_diag), .cfg_we(cfg_we), .cfg_qual(cfg_qual),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch), .o_INDEL_dd(o_INDEL_dd),
    .o_I_d(o_I_d), .o_A_dd(o_A_dd), .o_A_d_add_M2I(o_A_d_add_M2I), .o_Max(o_Max),
    .o_valid_d(o_valid_d), .o_valid_dd(o_valid_dd), .o_valid_ddd(o_valid_ddd),
    .o_hap_base(o_hap_base), .o_max_pos(o_max_pos), .o_sat(o_sat)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic int sadd(input int a, input int b, output bit hit);
    int s;
    s = a + b;
    hit = 1'b0;
    if (s > POS) begin s = POS; hit = (a != NEG); end
    else if (s < NEG) begin s = NEG; hit = (a != NEG); end
    return s;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  int m_tm[4], m_tx[4];
  int m_Ad, m_Id, m_Dd, m_Add, m_IN, m_V, m_Max, m_pos, m_col, m_cold, m_pdd, m_hap;
  bit m_vd, m_vdd, m_vddd, m_sat;

  function automatic void model_clear();
    m_Ad = NEG; m_Id = NEG; m_Dd = NEG; m_Add = NEG; m_IN = NEG; m_V = NEG; m_Max = NEG;
    m_pos = 0; m_col = 0; m_cold = 0; m_pdd = 0; m_hap = 0;
    m_vd = 0; m_vdd = 0; m_vddd = 0; m_sat = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    for (int q = 0; q < 4; q++) begin m_tm[q] = 2; m_tx[q] = -8; end
  endfunction

  function automatic void model_edge();
    int prior, a1, a2, ad, it, m2i, dt;
    bit h1, h2, h3, h4, h5, h6;
    if (refresh) model_clear();
    else begin
      if (m_vdd && m_V > m_Max) begin m_Max = m_V; m_pos = m_pdd; end
      if (m_vd) begin m_IN = imax(m_Dd, m_Id); m_V = imax(m_Id, m_Ad); m_pdd = m_cold; end
      m_Add = m_Ad;
      if (i_en) begin
        if (i_read_n) prior = 0;
        else if (i_hap_base == i_read_base) prior = m_tm[i_read_qual];
        else prior = m_tx[i_read_qual];
        a1  = sadd(int'(i_A_diag), M2M, h1);
        a2  = sadd(int'(i_INDEL_diag), I2M, h2);
        ad  = sadd(imax(a1, a2), prior, h3);
        it  = sadd(int'(i_I_top), I2I, h4);
        m2i = sadd(m_Ad, M2I, h5);
        dt  = sadd(m_Dd, I2I, h6);
        m_Ad = ad;
        m_Id = imax(int'(i_A_top_add_M2I), it);
        m_Dd = imax(m2i, dt);
        m_cold = m_col;
        m_col = (m_col + 1) % 1024;
        if (h1 | h2 | h3 | h4 | h5 | h6) m_sat = 1'b1;
      end
      m_vddd = m_vdd; m_vdd = m_vd; m_vd = i_en; m_hap = int'(i_hap_base);
    end
    if (cfg_we) begin m_tm[cfg_qual] = int'(cfg_match); m_tx[cfg_qual] = int'(cfg_mismatch); end
  endfunction

  task automatic compare_all();
    bit h;
    chk("m_A_d_add_M2I", o_A_d_add_M2I, sadd(m_Ad, M2I, h));
    chk("m_I_d", o_I_d, m_Id);
    chk("m_A_dd", o_A_dd, m_Add);
    chk("m_INDEL_dd", o_INDEL_dd, m_IN);
    chk("m_Max", o_Max, m_Max);
    chk("m_max_pos", o_max_pos, m_pos);
    chk("m_valid_d", o_valid_d, m_vd);
    chk("m_valid_dd", o_valid_dd, m_vdd);
    chk("m_valid_ddd", o_valid_ddd, m_vddd);
    chk("m_hap_base", o_hap_base, m_hap);
    chk("m_sat", o_sat, m_sat);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_cell(input int ad, input int indel, input int top, input int itop,
                          input bit match, input int q, input bit rn);
    i_en = 1'b1;
    i_A_diag = 16'(ad); i_INDEL_diag = 16'(indel);
    i_A_top_add_M2I = 16'(top); i_I_top = 16'(itop);
    i_hap_base = 2'd1; i_read_base = match ? 2'd1 : 2'd2;
    i_read_qual = 2'(q); i_read_n = rn;
  endtask

  task automatic idle();
    i_en = 1'b0;
  endtask

  task automatic do_refresh();
    idle();
    refresh = 1'b1;
    cycle();
    refresh = 1'b0;
  endtask

  // Cell producing V == v with a neutral prior.
  task automatic v_cell(input int v);
    set_cell(v + 1, -1000, -1000, -1000, 1'b1, 0, 1'b1);
  endtask

  typedef struct {
    int ad, indel, top, itop;
    bit match;
    int q;
    bit rn;
    int e_Ad, e_m2i, e_Id, e_max, e_sat;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{100, 50, 10, 20, 1'b1, 3, 1'b0, 101, 95, 18, 101, 0};
    vt[1] = '{0, 10, -5, 100, 1'b0, 0, 1'b0, -2, -8, 98, 98, 0};
    vt[2] = '{40, 40, 0, 0, 1'b1, 2, 1'b1, 39, 33, 0, 39, 0};
    vt[3] = '{32767, 0, 0, 0, 1'b1, 1, 1'b0, 32767, 32761, 0, 32767, 1};
    vt[4] = '{-32768, -32768, -32768, -32768, 1'b0, 0, 1'b0, -32768, -32768, -32768, -32768, 0};

    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_Max", o_Max, -32768);
    chk("rst_A_d_add_M2I", o_A_d_add_M2I, -32768);
    chk("rst_valid_ddd", o_valid_ddd, 0);
    chk("rst_max_pos", o_max_pos, 0);
    chk("rst_sat", o_sat, 0);
    rst_n = 1'b1;
    cycle();

    // table-driven single-cell vectors
    for (int k = 0; k < 5; k++) begin
      do_refresh();
      chk("vec_sat_after_refresh", o_sat, 0);
      set_cell(vt[k].ad, vt[k].indel, vt[k].top, vt[k].itop, vt[k].match, vt[k].q, vt[k].rn);
      cycle();
      idle();
      chk("vec_A_d_add_M2I", o_A_d_add_M2I, vt[k].e_m2i);
      chk("vec_I_d", o_I_d, vt[k].e_Id);
      cycle();
      chk("vec_A_dd", o_A_dd, vt[k].e_Ad);
      chk("vec_valid_ddd_early", o_valid_ddd, 0);
      cycle();
      chk("vec_Max", o_Max, vt[k].e_max);
      chk("vec_valid_ddd", o_valid_ddd, 1);
      chk("vec_max_pos", o_max_pos, 0);
      chk("vec_sat", o_sat, vt[k].e_sat);
    end

    // prior table writes
    do_refresh();
    cfg_we = 1'b1; cfg_qual = 2'd1; cfg_match = 8'sd5; cfg_mismatch = -8'sd3;
    cycle();
    cfg_we = 1'b0;
    set_cell(100, 0, -100, -100, 1'b1, 1, 1'b0);
    cycle();
    chk("tab_written", o_A_d_add_M2I, 98);
    cfg_we = 1'b1; cfg_qual = 2'd2; cfg_match = 8'sd7; cfg_mismatch = -8'sd1;
    set_cell(100, 0, -100, -100, 1'b1, 2, 1'b0);
    cycle();
    cfg_we = 1'b0;
    chk("tab_same_cycle_old", o_A_d_add_M2I, 95);
    set_cell(100, 0, -100, -100, 1'b1, 2, 1'b0);
    cycle();
    chk("tab_after_write", o_A_d_add_M2I, 100);
    set_cell(100, 0, -100, -100, 1'b1, 1, 1'b1);
    cycle();
    chk("tab_read_n", o_A_d_add_M2I, 93);
    set_cell(100, 0, -100, -100, 1'b0, 1, 1'b0);
    cycle();
    chk("tab_mismatch", o_A_d_add_M2I, 90);
    idle();

    // argmax with a gap and a tie
    do_refresh();
    v_cell(10); cycle();
    v_cell(30); cycle();
    idle(); cycle(); cycle();
    v_cell(30); cycle();
    v_cell(20); cycle();
    idle(); cycle(); cycle(); cycle();
    chk("argmax_Max", o_Max, 30);
    chk("argmax_pos", o_max_pos, 1);

    // refresh mid-stream, colliding with a cell
    v_cell(50); cycle();
    v_cell(60); cycle();
    v_cell(500); refresh = 1'b1; cycle(); refresh = 1'b0;
    set_cell(41, -1000, -1000, -1000, 1'b1, 1, 1'b0);
    cycle();
    idle(); cycle(); cycle();
    chk("refresh_Max", o_Max, 45);
    chk("refresh_pos", o_max_pos, 0);

    // asynchronous reset mid-stream
    v_cell(70); cycle();
    v_cell(80); cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_Max", o_Max, -32768);
    chk("arst_I_d", o_I_d, -32768);
    chk("arst_INDEL_dd", o_INDEL_dd, -32768);
    chk("arst_A_dd", o_A_dd, -32768);
    chk("arst_A_d_add_M2I", o_A_d_add_M2I, -32768);
    chk("arst_valid_d", o_valid_d, 0);
    chk("arst_max_pos", o_max_pos, 0);
    #1 rst_n = 1'b1;
    set_cell(41, -1000, -1000, -1000, 1'b1, 1, 1'b0);
    cycle();
    chk("arst_table_default", o_A_d_add_M2I, 36);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      int sel;
      i_en = ($urandom % 4) != 0;
      refresh = ($urandom % 50) == 0;
      cfg_we = ($urandom % 20) == 0;
      cfg_qual = 2'($urandom);
      cfg_match = 8'($urandom);
      cfg_mismatch = 8'($urandom);
      i_hap_base = 2'($urandom);
      i_read_base = ($urandom % 2) ? i_hap_base : 2'($urandom);
      i_read_qual = 2'($urandom);
      i_read_n = ($urandom % 8) == 0;
      for (int j = 0; j < 4; j++) begin
        int v;
        sel = $urandom % 16;
        case (sel)
          0: v = NEG;
          1: v = POS;
          2: v = NEG + 3;
          3: v = POS - 1;
          default: v = int'($urandom_range(0, 6000)) - 3000;
        endcase
        case (j)
          0: i_A_diag = 16'(v);
          1: i_INDEL_diag = 16'(v);
          2: i_A_top_add_M2I = 16'(v);
          default: i_I_top = 16'(v);
        endcase
      end
      cycle();
    end
    refresh = 1'b0; cfg_we = 1'b0; idle();
    cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
